// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared response codes and FSM state types for the AXI4-Lite register file slave
// Contents:
//   resp_t     : AXI response encoding (OKAY, EXOKAY, SLVERR, DECERR)
//   wr_state_t : write channel FSM states
//   rd_state_t : read channel FSM states
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4lite_regfile_slave_if.sv
// rtl/axi4lite_regfile_slave_if.sv - AXI4-Lite bus bundle with master and slave modports
// Parameters: ADDR_W address width, DATA_W data width (32 or 64)
// Signals:
//   AW_VALID/AW_READY/AW_ADDR/AW_PROT  write address channel
//   W_VALID/W_READY/W_DATA/W_STRB      write data channel
//   B_VALID/B_READY/B_RESP             write response channel
//   AR_VALID/AR_READY/AR_ADDR/AR_PROT  read address channel
//   R_VALID/R_READY/R_DATA/R_RESP      read data channel
interface axi4lite_regfile_slave_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic              AW_VALID;
  logic              AW_READY;
  logic [ADDR_W-1:0] AW_ADDR;
  logic [2:0]        AW_PROT;

  logic                W_VALID;
  logic                W_READY;
  logic [DATA_W-1:0]   W_DATA;
  logic [DATA_W/8-1:0] W_STRB;

  logic       B_VALID;
  logic       B_READY;
  logic [1:0] B_RESP;

  logic              AR_VALID;
  logic              AR_READY;
  logic [ADDR_W-1:0] AR_ADDR;
  logic [2:0]        AR_PROT;

  logic              R_VALID;
  logic              R_READY;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, AW_PROT,
    output W_VALID, W_DATA, W_STRB,
    output B_READY,
    output AR_VALID, AR_ADDR, AR_PROT,
    output R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP,
    input  AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, AW_PROT,
    input  W_VALID, W_DATA, W_STRB,
    input  B_READY,
    input  AR_VALID, AR_ADDR, AR_PROT,
    input  R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP,
    output AR_READY, R_VALID, R_DATA, R_RESP
  );

endinterface

// File: rtl/axi4lite_addr_decode.sv
// rtl/axi4lite_addr_decode.sv - combinational byte-address to register-index decoder with bounds check
// Parameters: ADDR_W, DATA_W, NUM_REGS
// Ports:
//   addr     in  ADDR_W  byte address
//   index    out IDX_W   register index (word-aligned bits of addr)
//   in_range out 1       addr < NUM_REGS*DATA_W/8
module axi4lite_addr_decode #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int LSB     = $clog2(DATA_W/8),
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  index,
  output logic              in_range
);

  localparam int TOP = LSB + IDX_W;

  assign index = addr[LSB +: IDX_W];

  // Sub-word byte offset does not select anything.
  logic unused_offset;
  assign unused_offset = ^addr[LSB-1:0];

  // The register window is a power of two, so in range means all bits above it are zero.
  generate
    if (ADDR_W > TOP) begin : g_bound
      assign in_range = (addr[ADDR_W-1:TOP] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// rtl/axi4lite_regfile_slave.sv - AXI4-Lite slave with a bounds-checked, byte-strobed register file
// Optional feature macro: AXI4LITE_PROT_CHECK_EN (privileged-write checking against PRIV_MASK)
// Parameters: ADDR_W, DATA_W (32/64), NUM_REGS (power of two >= 2), RO_MASK, PRIV_MASK
// Ports:
//   A_CLK         in   clock
//   A_RSTn        in   asynchronous active-low reset
//   bus           slave modport of axi4lite_regfile_slave_if (AW/W/B/AR/R channels)
//   reg_q         out  NUM_REGS*DATA_W register contents, register i at [i*DATA_W +: DATA_W]
//   reg_wr_pulse  out  NUM_REGS one-cycle pulse per committed register write
module axi4lite_regfile_slave
  import axi4lite_pkg::*;
#(
  parameter int                  ADDR_W    = 12,
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0] PRIV_MASK = '0
) (
  input  logic                         A_CLK,
  input  logic                         A_RSTn,
  axi4lite_regfile_slave_if.slave      bus,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Holds every ready low until the first edge after reset release.
  logic active_q;
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) active_q <= 1'b0;
    else         active_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write path
  wr_state_t wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  resp_t             b_resp_q;
  logic              aw_ready, w_ready, b_valid;
  logic              aw_hs, w_hs;

  assign aw_ready = active_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_DATA);
  assign w_ready  = active_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_ADDR);
  assign aw_hs    = bus.AW_VALID && aw_ready;
  assign w_hs     = bus.W_VALID && w_ready;

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) wr_state_q <= WR_IDLE;
    else         wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    b_valid    = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = WR_COMMIT;
        else if (aw_hs)    wr_state_d = WR_HAVE_ADDR;
        else if (w_hs)     wr_state_d = WR_HAVE_DATA;
      end
      WR_HAVE_ADDR: if (w_hs)  wr_state_d = WR_COMMIT;
      WR_HAVE_DATA: if (aw_hs) wr_state_d = WR_COMMIT;
      WR_COMMIT:    wr_state_d = WR_RESP;
      WR_RESP: begin
        b_valid = 1'b1;
        if (bus.B_READY) wr_state_d = WR_IDLE;
      end
      default:      wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= bus.AW_ADDR;
      if (w_hs) begin
        w_data_q <= bus.W_DATA;
        w_strb_q <= bus.W_STRB;
      end
    end
  end

  logic [IDX_W-1:0] wr_index;
  logic             wr_in_range;
  logic             wr_priv_err;
  resp_t            wr_resp;

  axi4lite_addr_decode #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_decode (
    .addr     (aw_addr_q),
    .index    (wr_index),
    .in_range (wr_in_range)
  );

`ifdef AXI4LITE_PROT_CHECK_EN
  // AW_PROT[0] is latched alongside the address so it matches the committed write.
  logic aw_priv_q;
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn)    aw_priv_q <= 1'b0;
    else if (aw_hs) aw_priv_q <= bus.AW_PROT[0];
  end
  assign wr_priv_err = PRIV_MASK[wr_index] && !aw_priv_q;
  logic unused_prot;
  assign unused_prot = ^{bus.AR_PROT, bus.AW_PROT[2:1]};
`else
  assign wr_priv_err = 1'b0;
  logic unused_prot;
  assign unused_prot = ^{bus.AR_PROT, bus.AW_PROT, PRIV_MASK};
`endif

  // Precedence: DECERR, then read-only SLVERR, then privilege SLVERR.
  always_comb begin
    wr_resp = OKAY;
    if (!wr_in_range)           wr_resp = DECERR;
    else if (RO_MASK[wr_index]) wr_resp = SLVERR;
    else if (wr_priv_err)       wr_resp = SLVERR;
  end

  // Register file, write pulses and the write response all update on the WR_COMMIT exit edge.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
      b_resp_q     <= OKAY;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_state_q == WR_COMMIT) begin
        b_resp_q <= wr_resp;
        // An all-zero strobe is a legal no-op: OKAY but nothing written, no pulse.
        if (wr_resp == OKAY && |w_strb_q) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs[wr_index][b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
          reg_wr_pulse[wr_index] <= 1'b1;
        end
      end
    end
  end

  assign bus.AW_READY = aw_ready;
  assign bus.W_READY  = w_ready;
  assign bus.B_VALID  = b_valid;
  assign bus.B_RESP   = b_resp_q;

  // ----------------------------------------------------------------- read path
  rd_state_t         rd_state_q, rd_state_d;
  logic              ar_ready, ar_hs, r_valid;
  logic [DATA_W-1:0] r_data_q;
  resp_t             r_resp_q;
  logic [IDX_W-1:0]  rd_index;
  logic              rd_in_range;

  assign ar_ready = active_q && (rd_state_q == RD_IDLE);
  assign ar_hs    = bus.AR_VALID && ar_ready;

  axi4lite_addr_decode #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_decode (
    .addr     (bus.AR_ADDR),
    .index    (rd_index),
    .in_range (rd_in_range)
  );

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) rd_state_q <= RD_IDLE;
    else         rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    r_valid    = 1'b0;
    case (rd_state_q)
      RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
      RD_RESP: begin
        r_valid = 1'b1;
        if (bus.R_READY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Sampling regs on the handshake edge returns the pre-commit value if a write lands on the same edge.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      r_data_q <= '0;
      r_resp_q <= OKAY;
    end else if (ar_hs) begin
      r_data_q <= rd_in_range ? regs[rd_index] : '0;
      r_resp_q <= rd_in_range ? OKAY : DECERR;
    end
  end

  assign bus.AR_READY = ar_ready;
  assign bus.R_VALID  = r_valid;
  assign bus.R_DATA   = r_data_q;
  assign bus.R_RESP   = r_resp_q;

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
      assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb/tb_axi4lite_regfile_slave.sv - directed self-checking bench for axi4lite_regfile_slave
module tb_axi4lite_regfile_slave;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam logic [NUM_REGS-1:0] RO_MASK   = 16'h0008;
  localparam logic [NUM_REGS-1:0] PRIV_MASK = 16'h0010;

  logic A_CLK = 1'b0;
  logic A_RSTn = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        reg_wr_pulse;

  int checks = 0;
  int failures = 0;

  axi4lite_regfile_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  axi4lite_regfile_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK),
    .PRIV_MASK (PRIV_MASK)
  ) dut (
    .A_CLK        (A_CLK),
    .A_RSTn       (A_RSTn),
    .bus          (bus),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  always #5 A_CLK = ~A_CLK;

  function automatic logic [31:0] reg_at(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic write_txn(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, output logic [1:0] resp,
                           output logic [15:0] pulses, output logic [15:0] pulse_late, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    bus.AW_ADDR = addr; bus.AW_PROT = prot; bus.AW_VALID = 1'b1;
    bus.W_DATA = data;  bus.W_STRB = strb;  bus.W_VALID = 1'b1;
    bus.B_READY = 1'b0;
    aw_done = 0; w_done = 0; n = 0; pulses = '0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.AW_VALID && bus.AW_READY;
      w_hs  = bus.W_VALID && bus.W_READY;
      tick(); n++;
      if (aw_hs) begin aw_done = 1; bus.AW_VALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.W_VALID = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      checks++; failures++;
      $display("FAIL wr_handshake_timeout addr=%h got aw=%0d w=%0d required 1 1", addr, aw_done, w_done);
      bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    end
    lat = 1;
    pulses |= reg_wr_pulse;
    while (!bus.B_VALID && lat < 20) begin
      tick(); lat++;
      pulses |= reg_wr_pulse;
    end
    if (!bus.B_VALID) begin
      checks++; failures++;
      $display("FAIL b_valid_timeout addr=%h got 0 required 1", addr);
    end
    resp = bus.B_RESP;
    bus.B_READY = 1'b1;
    tick();
    pulse_late = reg_wr_pulse;
    bus.B_READY = 1'b0;
  endtask

  task automatic read_txn(input logic [11:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit done, hs;
    int n;
    bus.AR_ADDR = addr; bus.AR_VALID = 1'b1; bus.R_READY = 1'b0;
    done = 0; n = 0;
    while (!done && n < 20) begin
      hs = bus.AR_VALID && bus.AR_READY;
      tick(); n++;
      if (hs) begin done = 1; bus.AR_VALID = 1'b0; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL ar_handshake_timeout addr=%h got 0 required 1", addr);
      bus.AR_VALID = 1'b0;
    end
    lat = 1;
    while (!bus.R_VALID && lat < 20) begin
      tick(); lat++;
    end
    data = bus.R_DATA;
    resp = bus.R_RESP;
    bus.R_READY = 1'b1;
    tick();
    bus.R_READY = 1'b0;
  endtask

  task automatic test_reset();
    A_RSTn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID} !== 5'b0) begin
      failures++; $display("FAIL reset_handshake got %b required 00000",
        {bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID});
    end
    checks++;
    if ({bus.B_RESP, bus.R_RESP, bus.R_DATA, reg_wr_pulse} !== '0) begin
      failures++; $display("FAIL reset_data got b=%h r=%h d=%h p=%h required 0",
        bus.B_RESP, bus.R_RESP, bus.R_DATA, reg_wr_pulse);
    end
    checks++;
    if (reg_q !== '0) begin failures++; $display("FAIL reset_regs got nonzero required 0"); end
    @(negedge A_CLK);
    A_RSTn = 1'b1;
    #1;
    checks++;
    if (bus.AW_READY !== 1'b0) begin failures++; $display("FAIL ready_before_edge got %b required 0", bus.AW_READY); end
    tick();
    checks++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY} !== 3'b111) begin
      failures++; $display("FAIL ready_after_edge got %b required 111", {bus.AW_READY, bus.W_READY, bus.AR_READY});
    end
  endtask

  task automatic test_basic_write_read();
    logic [1:0] resp; logic [15:0] p, pl; logic [31:0] d; int lat;
    write_txn(12'h004, 32'hDEADBEEF, 4'hF, 3'b000, resp, p, pl, lat);
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL t1_bresp got %b required 00", resp); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL t1_b_latency got %0d required 2", lat); end
    checks++; if (p !== 16'h0002) begin failures++; $display("FAIL t1_pulse got %h required 0002", p); end
    checks++; if (pl !== 16'h0000) begin failures++; $display("FAIL t1_pulse_width got %h required 0000", pl); end
    checks++; if (reg_at(1) !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_reg1 got %h required deadbeef", reg_at(1)); end
    read_txn(12'h004, d, resp, lat);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_rdata got %h required deadbeef", d); end
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL t1_rresp got %b required 00", resp); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL t1_r_latency got %0d required 1", lat); end
  endtask

  task automatic test_w_before_aw();
    bus.W_DATA = 32'h11223344; bus.W_STRB = 4'h5; bus.W_VALID = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    checks++;
    if ({bus.W_READY, bus.AW_READY} !== 2'b01) begin
      failures++; $display("FAIL t2_have_data_readies got %b required 01", {bus.W_READY, bus.AW_READY});
    end
    repeat (2) tick();
    checks++; if (bus.W_READY !== 1'b0) begin failures++; $display("FAIL t2_w_ready_held got %b required 0", bus.W_READY); end
    bus.AW_ADDR = 12'h008; bus.AW_PROT = 3'b000; bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    checks++; if (bus.B_VALID !== 1'b0) begin failures++; $display("FAIL t2_commit_bvalid got %b required 0", bus.B_VALID); end
    tick();
    checks++;
    if ({bus.B_VALID, bus.B_RESP, bus.W_READY} !== 4'b1000) begin
      failures++; $display("FAIL t2_resp got bv=%b br=%b wr=%b required 1 00 0", bus.B_VALID, bus.B_RESP, bus.W_READY);
    end
    checks++; if (reg_wr_pulse !== 16'h0004) begin failures++; $display("FAIL t2_pulse got %h required 0004", reg_wr_pulse); end
    bus.B_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0;
    checks++;
    if ({bus.B_VALID, bus.AW_READY, bus.W_READY} !== 3'b011) begin
      failures++; $display("FAIL t2_after_b got %b required 011", {bus.B_VALID, bus.AW_READY, bus.W_READY});
    end
    checks++; if (reg_at(2) !== 32'h00220044) begin failures++; $display("FAIL t2_reg2 got %h required 00220044", reg_at(2)); end
  endtask

  task automatic test_decode_bounds();
    logic [1:0] resp; logic [15:0] p, pl; logic [31:0] d; int lat;
    write_txn(12'h040, 32'hCAFEF00D, 4'hF, 3'b000, resp, p, pl, lat);
    checks++; if (resp !== 2'b11) begin failures++; $display("FAIL t3_oor_bresp got %b required 11", resp); end
    checks++; if (p !== 16'h0000) begin failures++; $display("FAIL t3_oor_pulse got %h required 0000", p); end
    read_txn(12'h040, d, resp, lat);
    checks++; if ({d, resp} !== {32'h0, 2'b11}) begin failures++; $display("FAIL t3_oor_read got %h/%b required 00000000/11", d, resp); end
    read_txn(12'hFFC, d, resp, lat);
    checks++; if ({d, resp} !== {32'h0, 2'b11}) begin failures++; $display("FAIL t3_top_read got %h/%b required 00000000/11", d, resp); end
    write_txn(12'h03E, 32'h1234BEEF, 4'h3, 3'b000, resp, p, pl, lat);
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL t3_last_bresp got %b required 00", resp); end
    checks++; if (p !== 16'h8000) begin failures++; $display("FAIL t3_last_pulse got %h required 8000", p); end
    checks++; if (reg_at(15) !== 32'h0000BEEF) begin failures++; $display("FAIL t3_reg15 got %h required 0000beef", reg_at(15)); end
    write_txn(12'h004, 32'h00000000, 4'h0, 3'b000, resp, p, pl, lat);
    checks++; if ({resp, p} !== {2'b00, 16'h0000}) begin failures++; $display("FAIL t3_zero_strb got %b/%h required 00/0000", resp, p); end
    checks++; if (reg_at(1) !== 32'hDEADBEEF) begin failures++; $display("FAIL t3_zero_strb_reg got %h required deadbeef", reg_at(1)); end
  endtask

  task automatic test_ro_and_prot();
    logic [1:0] resp; logic [15:0] p, pl; logic [31:0] d; int lat;
    logic [1:0] exp_resp; logic [15:0] exp_p; logic [31:0] exp_reg4;
    write_txn(12'h00C, 32'hFFFFFFFF, 4'hF, 3'b000, resp, p, pl, lat);
    checks++; if (resp !== 2'b10) begin failures++; $display("FAIL t4_ro_bresp got %b required 10", resp); end
    checks++; if (p !== 16'h0000) begin failures++; $display("FAIL t4_ro_pulse got %h required 0000", p); end
    checks++; if (reg_at(3) !== 32'h0) begin failures++; $display("FAIL t4_ro_reg got %h required 00000000", reg_at(3)); end
    read_txn(12'h00C, d, resp, lat);
    checks++; if ({d, resp} !== {32'h0, 2'b00}) begin failures++; $display("FAIL t4_ro_read got %h/%b required 00000000/00", d, resp); end
`ifdef AXI4LITE_PROT_CHECK_EN
    exp_resp = 2'b10; exp_p = 16'h0000; exp_reg4 = 32'h00000000;
`else
    exp_resp = 2'b00; exp_p = 16'h0010; exp_reg4 = 32'h00000044;
`endif
    write_txn(12'h010, 32'h00000044, 4'hF, 3'b000, resp, p, pl, lat);
    checks++; if (resp !== exp_resp) begin failures++; $display("FAIL t4_unpriv_bresp got %b required %b", resp, exp_resp); end
    checks++; if (p !== exp_p) begin failures++; $display("FAIL t4_unpriv_pulse got %h required %h", p, exp_p); end
    checks++; if (reg_at(4) !== exp_reg4) begin failures++; $display("FAIL t4_unpriv_reg got %h required %h", reg_at(4), exp_reg4); end
    write_txn(12'h010, 32'h00000055, 4'hF, 3'b001, resp, p, pl, lat);
    checks++; if ({resp, p} !== {2'b00, 16'h0010}) begin failures++; $display("FAIL t4_priv got %b/%h required 00/0010", resp, p); end
    checks++; if (reg_at(4) !== 32'h00000055) begin failures++; $display("FAIL t4_priv_reg got %h required 00000055", reg_at(4)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] resp; int lat;
    bus.B_READY = 1'b0; bus.R_READY = 1'b0;
    bus.AW_ADDR = 12'h014; bus.AW_PROT = 3'b000; bus.AW_VALID = 1'b1;
    bus.W_DATA = 32'hA5A50001; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    bus.AR_ADDR = 12'h014; bus.AR_VALID = 1'b1;
    checks++; if (bus.AR_READY !== 1'b1) begin failures++; $display("FAIL t5_ar_ready_during_write got %b required 1", bus.AR_READY); end
    tick();
    bus.AR_VALID = 1'b0;
    checks++;
    if ({bus.R_VALID, bus.R_DATA, bus.R_RESP} !== {1'b1, 32'h0, 2'b00}) begin
      failures++; $display("FAIL t5_read_old_value got %b/%h/%b required 1/00000000/00", bus.R_VALID, bus.R_DATA, bus.R_RESP);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.B_VALID, bus.B_RESP, bus.R_VALID, bus.R_DATA, bus.R_RESP, bus.AW_READY, bus.W_READY, bus.AR_READY}
          !== {1'b1, 2'b00, 1'b1, 32'h0, 2'b00, 3'b000}) begin
        failures++; $display("FAIL t5_stall_%0d got bv=%b br=%b rv=%b rd=%h rr=%b rdy=%b required 1 00 1 00000000 00 000",
          i, bus.B_VALID, bus.B_RESP, bus.R_VALID, bus.R_DATA, bus.R_RESP, {bus.AW_READY, bus.W_READY, bus.AR_READY});
      end
    end
    checks++; if (reg_at(5) !== 32'hA5A50001) begin failures++; $display("FAIL t5_reg5 got %h required a5a50001", reg_at(5)); end
    bus.B_READY = 1'b1; bus.R_READY = 1'b1;
    tick();
    bus.B_READY = 1'b0; bus.R_READY = 1'b0;
    checks++;
    if ({bus.B_VALID, bus.R_VALID, bus.AW_READY, bus.W_READY, bus.AR_READY} !== 5'b00111) begin
      failures++; $display("FAIL t5_release got %b required 00111",
        {bus.B_VALID, bus.R_VALID, bus.AW_READY, bus.W_READY, bus.AR_READY});
    end
    read_txn(12'h014, d, resp, lat);
    checks++; if ({d, resp} !== {32'hA5A50001, 2'b00}) begin failures++; $display("FAIL t5_reread got %h/%b required a5a50001/00", d, resp); end
  endtask

  task automatic test_reset_midway();
    logic [1:0] resp; logic [15:0] p, pl; int lat;
    bus.AW_ADDR = 12'h010; bus.AW_PROT = 3'b001; bus.AW_VALID = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    checks++;
    if ({bus.AW_READY, bus.W_READY} !== 2'b01) begin
      failures++; $display("FAIL t6_have_addr got %b required 01", {bus.AW_READY, bus.W_READY});
    end
    checks++; if (reg_at(1) !== 32'hDEADBEEF) begin failures++; $display("FAIL t6_pre_reg1 got %h required deadbeef", reg_at(1)); end
    A_RSTn = 1'b0;
    #1;
    checks++; if (reg_q !== '0) begin failures++; $display("FAIL t6_regs_cleared got reg1=%h reg5=%h required 0", reg_at(1), reg_at(5)); end
    checks++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID, bus.B_RESP, bus.R_RESP, bus.R_DATA, reg_wr_pulse} !== '0) begin
      failures++; $display("FAIL t6_outputs_reset got rdy=%b rd=%h required 0",
        {bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID}, bus.R_DATA);
    end
    @(negedge A_CLK);
    A_RSTn = 1'b1;
    tick();
    checks++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY} !== 3'b111) begin
      failures++; $display("FAIL t6_ready_after got %b required 111", {bus.AW_READY, bus.W_READY, bus.AR_READY});
    end
    write_txn(12'h004, 32'h12345678, 4'hF, 3'b000, resp, p, pl, lat);
    checks++; if ({resp, p} !== {2'b00, 16'h0002}) begin failures++; $display("FAIL t6_first_write got %b/%h required 00/0002", resp, p); end
    checks++; if (reg_at(1) !== 32'h12345678) begin failures++; $display("FAIL t6_reg1 got %h required 12345678", reg_at(1)); end
    checks++; if (reg_at(4) !== 32'h0) begin failures++; $display("FAIL t6_reg4_discarded got %h required 00000000", reg_at(4)); end
  endtask

  initial begin
    bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.AW_PROT = '0;
    bus.W_VALID = 1'b0;  bus.W_DATA = '0;  bus.W_STRB = '0;
    bus.B_READY = 1'b0;
    bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.AR_PROT = '0;
    bus.R_READY = 1'b0;
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_decode_bounds();
    test_ro_and_prot();
    test_backpressure();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
